// File: rtl/huff_code_sched_if.sv
// Huffman code scheduler bus: table load, per-code handshake and status.
// Optional adj_count signal is present when HUFF_SCHED_ADJ_COUNT_EN is defined.
interface huff_code_sched_if #(
    parameter int unsigned SYMBOLS  = 16,
    parameter int unsigned MAX_BITS = 16
);
    logic                    start;
    logic [8*MAX_BITS-1:0]   bits_packed;
    logic [8*SYMBOLS-1:0]    huffval_packed;
    logic                    busy;
    logic                    code_valid;
    logic                    code_ready;
    logic [7:0]              code_sym;
    logic [4:0]              code_len;
    logic [15:0]             code;
    logic                    done;
    logic                    err;
`ifdef HUFF_SCHED_ADJ_COUNT_EN
    logic [15:0]             adj_count;

    modport master (
        output start, bits_packed, huffval_packed, code_ready,
        input  busy, code_valid, code_sym, code_len, code, done, err, adj_count
    );

    modport slave (
        input  start, bits_packed, huffval_packed, code_ready,
        output busy, code_valid, code_sym, code_len, code, done, err, adj_count
    );
`else
    modport master (
        output start, bits_packed, huffval_packed, code_ready,
        input  busy, code_valid, code_sym, code_len, code, done, err
    );

    modport slave (
        input  start, bits_packed, huffval_packed, code_ready,
        output busy, code_valid, code_sym, code_len, code, done, err
    );
`endif
endinterface

// File: rtl/huff_code_sched.sv
// Huffman code scheduler: latches a BITS/HUFFVAL table, validates it, limits
// code lengths to MAX_LEN with the JPEG adjust procedure, then emits
// canonical codes one per handshake.
// Define HUFF_SCHED_ADJ_COUNT_EN to add the saturating adj_count output.
module huff_code_sched #(
    parameter int unsigned SYMBOLS  = 16,
    parameter int unsigned MAX_BITS = 16,
    parameter int unsigned MAX_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    huff_code_sched_if.slave  bus
);

    localparam int unsigned IW  = $clog2(MAX_BITS + 1);
    localparam int unsigned NW  = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
    localparam int unsigned CAP = 32'd1 << MAX_LEN;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ADJ_SEARCH,
        ADJ_APPLY,
        EMIT,
        FIN
    } state_t;

    state_t          r_state;
    logic [7:0]      r_bits [0:MAX_BITS];
    logic [7:0]      r_hv   [0:SYMBOLS-1];
    logic [11:0]     r_total;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_j;
    logic            r_jscan;
    logic [IW-1:0]   r_len;
    logic [15:0]     r_code;
    logic [11:0]     r_n;

    logic            r_busy;
    logic            r_code_valid;
    logic [7:0]      r_code_sym;
    logic [4:0]      r_code_len;
    logic [15:0]     r_code_out;
    logic            r_done;
    logic            r_err;

    logic [7:0]      w_bits_adj [0:MAX_BITS];
    logic [IW-1:0]   w_im1;
    logic [IW-1:0]   w_jp1;
    logic [11:0]     w_n1;
    logic [NW-1:0]   w_hv_idx;
    logic [NW-1:0]   w_hv_idx1;

    assign w_im1     = r_i - IW'(1);
    assign w_jp1     = r_j + IW'(1);
    assign w_n1      = r_n + 12'd1;
    assign w_hv_idx  = r_n[NW-1:0];
    assign w_hv_idx1 = w_n1[NW-1:0];

    // One adjust step; applied in order so that j+1 == i-1 accumulates both updates
    always_comb begin
        w_bits_adj        = r_bits;
        w_bits_adj[r_i]   = w_bits_adj[r_i]   - 8'd2;
        w_bits_adj[w_im1] = w_bits_adj[w_im1] + 8'd1;
        w_bits_adj[w_jp1] = w_bits_adj[w_jp1] + 8'd2;
        w_bits_adj[r_j]   = w_bits_adj[r_j]   - 8'd1;
    end

    // Main sequencer: table load, validation, length limiting and code emission
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            for (int unsigned k = 0; k <= MAX_BITS; k++) r_bits[k] <= '0;
            for (int unsigned k = 0; k < SYMBOLS; k++)   r_hv[k]   <= '0;
            r_total      <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_jscan      <= 1'b0;
            r_len        <= '0;
            r_code       <= '0;
            r_n          <= '0;
            r_busy       <= 1'b0;
            r_code_valid <= 1'b0;
            r_code_sym   <= '0;
            r_code_len   <= '0;
            r_code_out   <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_bits[0] <= '0;
                        for (int unsigned k = 1; k <= MAX_BITS; k++)
                            r_bits[k] <= bus.bits_packed[8*k-1 -: 8];
                        for (int unsigned k = 0; k < SYMBOLS; k++)
                            r_hv[k] <= bus.huffval_packed[8*k+7 -: 8];
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_total <= '0;
                        r_i     <= IW'(1);
                        r_state <= LOAD;
                    end
                end

                LOAD: begin
                    r_total <= r_total + {4'b0, r_bits[r_i]};
                    if (r_i == IW'(MAX_BITS))
                        r_state <= CHECK;
                    else
                        r_i <= r_i + IW'(1);
                end

                CHECK: begin
                    if ((32'(r_total) > SYMBOLS) || (32'(r_total) > CAP)) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else if (r_total == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_i     <= IW'(MAX_BITS);
                        r_jscan <= 1'b0;
                        r_state <= ADJ_SEARCH;
                    end
                end

                // r_jscan splits the state into the i-walk and the j-walk phases
                ADJ_SEARCH: begin
                    if (!r_jscan) begin
                        if (32'(r_i) <= MAX_LEN) begin
                            r_len   <= IW'(1);
                            r_code  <= '0;
                            r_n     <= '0;
                            r_state <= EMIT;
                        end else if (r_bits[r_i] == 8'd0) begin
                            r_i <= w_im1;
                        end else begin
                            r_j     <= r_i - IW'(2);
                            r_jscan <= 1'b1;
                        end
                    end else begin
                        if (r_j == '0) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_jscan <= 1'b0;
                            r_state <= FIN;
                        end else if (r_bits[r_j] != 8'd0) begin
                            r_jscan <= 1'b0;
                            r_state <= ADJ_APPLY;
                        end else begin
                            r_j <= r_j - IW'(1);
                        end
                    end
                end

                ADJ_APPLY: begin
                    if (r_bits[r_i] == 8'd1) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end else begin
                        r_bits  <= w_bits_adj;
                        r_state <= ADJ_SEARCH;
                    end
                end

                // r_bits[r_len] doubles as the remaining count for the current length;
                // a transfer presents the next same-length code in the same cycle
                EMIT: begin
                    if (r_code_valid) begin
                        if (bus.code_ready) begin
                            r_bits[r_len] <= r_bits[r_len] - 8'd1;
                            r_n           <= w_n1;
                            r_code        <= r_code + 16'd1;
                            if (w_n1 == r_total) begin
                                r_code_valid <= 1'b0;
                                r_done       <= 1'b1;
                                r_busy       <= 1'b0;
                                r_state      <= FIN;
                            end else if (r_bits[r_len] > 8'd1) begin
                                r_code_sym <= r_hv[w_hv_idx1];
                                r_code_out <= r_code + 16'd1;
                            end else begin
                                r_code_valid <= 1'b0;
                            end
                        end
                    end else if (r_bits[r_len] == 8'd0) begin
                        r_code <= r_code << 1;
                        r_len  <= r_len + IW'(1);
                    end else begin
                        r_code_valid <= 1'b1;
                        r_code_sym   <= r_hv[w_hv_idx];
                        r_code_len   <= 5'(r_len);
                        r_code_out   <= r_code;
                    end
                end

                FIN: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef HUFF_SCHED_ADJ_COUNT_EN
    logic [15:0] r_adj_count;

    // Counts ADJ_APPLY cycles of the current table, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_adj_count <= '0;
        else if ((r_state == IDLE) && bus.start)
            r_adj_count <= '0;
        else if ((r_state == ADJ_APPLY) && (r_adj_count != '1))
            r_adj_count <= r_adj_count + 16'd1;
    end

    assign bus.adj_count = r_adj_count;
`endif

    assign bus.busy       = r_busy;
    assign bus.code_valid = r_code_valid;
    assign bus.code_sym   = r_code_sym;
    assign bus.code_len   = r_code_len;
    assign bus.code       = r_code_out;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_huff_code_sched.sv
// Self-checking bench for huff_code_sched: directed tables plus randomized
// tables compared against a behavioural canonical-Huffman model.
`timescale 1ns/1ps
module tb_huff_code_sched;

    localparam int unsigned SYMBOLS  = 16;
    localparam int unsigned MAX_BITS = 16;
    localparam int unsigned MAX_LEN  = 4;

    typedef struct {
        logic [7:0]  sym;
        logic [4:0]  len;
        logic [15:0] code;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    huff_code_sched_if #(.SYMBOLS(SYMBOLS), .MAX_BITS(MAX_BITS)) bus ();

    huff_code_sched #(
        .SYMBOLS (SYMBOLS),
        .MAX_BITS(MAX_BITS),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   tb_bits [1:MAX_BITS];
    logic [7:0] tb_hv [0:SYMBOLS-1];
    exp_t exp_q[$];
    logic exp_err;
    int   exp_adj;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    endtask

    task automatic clear_tbl();
        for (int l = 1; l <= int'(MAX_BITS); l++) tb_bits[l] = 0;
        for (int n = 0; n < int'(SYMBOLS); n++) tb_hv[n] = 8'($urandom);
    endtask

    // Reference: validate, JPEG length limiting, canonical code assignment
    task automatic build_model();
        int b [0:MAX_BITS];
        int total, j, n;
        logic [15:0] c;
        exp_q.delete();
        exp_err = 1'b0;
        exp_adj = 0;
        total = 0;
        b[0] = 0;
        for (int l = 1; l <= int'(MAX_BITS); l++) begin
            b[l] = tb_bits[l];
            total += b[l];
        end
        if (total > int'(SYMBOLS) || total > (1 << MAX_LEN)) begin
            exp_err = 1'b1;
            return;
        end
        if (total == 0) return;
        for (int i = int'(MAX_BITS); i > int'(MAX_LEN); i--) begin
            while (b[i] > 0) begin
                j = i - 2;
                while (j > 0 && b[j] == 0) j--;
                if (j == 0) begin
                    exp_err = 1'b1;
                    exp_q.delete();
                    return;
                end
                exp_adj++;
                if (b[i] == 1) begin
                    exp_err = 1'b1;
                    return;
                end
                b[i]   -= 2;
                b[i-1] += 1;
                b[j+1] += 2;
                b[j]   -= 1;
            end
        end
        c = '0;
        n = 0;
        for (int l = 1; l <= int'(MAX_BITS); l++) begin
            for (int k = 0; k < b[l]; k++) begin
                exp_q.push_back('{sym: tb_hv[n], len: 5'(l), code: c});
                c = c + 16'd1;
                n++;
            end
            c = c << 1;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_busy"},  32'(bus.busy), 0);
        check({pfx, "_valid"}, 32'(bus.code_valid), 0);
        check({pfx, "_done"},  32'(bus.done), 0);
        check({pfx, "_err"},   32'(bus.err), 0);
        check({pfx, "_sym"},   32'(bus.code_sym), 0);
        check({pfx, "_len"},   32'(bus.code_len), 0);
        check({pfx, "_code"},  32'(bus.code), 0);
`ifdef HUFF_SCHED_ADJ_COUNT_EN
        check({pfx, "_adj"},   32'(bus.adj_count), 0);
`endif
    endtask

    // mode 0: ready always 1; 1: random ready; 2: ready low 3 cycles on 2nd code
    task automatic run_table(input int mode, input int rst_after, input bit start_in_fin);
        int   xfers = 0;
        int   stall = 0;
        bit   held = 1'b0;
        bit   finished = 1'b0;
        bit   rdy;
        logic [7:0]  hs;
        logic [4:0]  hl;
        logic [15:0] hc;
        build_model();
        for (int l = 1; l <= int'(MAX_BITS); l++) bus.bits_packed[8*l-1 -: 8] = 8'(tb_bits[l]);
        for (int n = 0; n < int'(SYMBOLS); n++)   bus.huffval_packed[8*n+7 -: 8] = tb_hv[n];
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_on_start", 32'(bus.busy), 1);
        check("err_clr_on_start", 32'(bus.err), 0);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
            if (mode == 2 && xfers == 1 && bus.code_valid && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end
            bus.code_ready = rdy;
            if (held) begin
                check("hold_valid", 32'(bus.code_valid), 1);
                check("hold_sym",   32'(bus.code_sym), 32'(hs));
                check("hold_len",   32'(bus.code_len), 32'(hl));
                check("hold_code",  32'(bus.code), 32'(hc));
            end
            if (bus.done) begin
                check("done_err",   32'(bus.err), 32'(exp_err));
                check("done_count", 32'(xfers), 32'(exp_q.size()));
                check("done_busy",  32'(bus.busy), 0);
                check("done_valid", 32'(bus.code_valid), 0);
`ifdef HUFF_SCHED_ADJ_COUNT_EN
                check("adj_count",  32'(bus.adj_count), 32'(exp_adj));
`endif
                if (start_in_fin) bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                check("done_one_cycle", 32'(bus.done), 0);
                check("err_hold", 32'(bus.err), 32'(exp_err));
                if (start_in_fin) begin
                    repeat (3) @(negedge clk);
                    check("fin_start_ignored", 32'(bus.busy), 0);
                end
                finished = 1'b1;
            end else if (bus.code_valid) begin
                if (rdy) begin
                    if (xfers < exp_q.size()) begin
                        check("code_sym",  32'(bus.code_sym), 32'(exp_q[xfers].sym));
                        check("code_len",  32'(bus.code_len), 32'(exp_q[xfers].len));
                        check("code_bits", 32'(bus.code),     32'(exp_q[xfers].code));
                    end else begin
                        check("extra_code", 32'(xfers), 32'(exp_q.size()));
                    end
                    xfers++;
                    held = 1'b0;
                    if (xfers == rst_after) begin
                        @(posedge clk);
                        #1 rst = 1'b1;
                        #1 check_all_zero("rst_mid");
                        @(negedge clk);
                        rst = 1'b0;
                        repeat (4) begin
                            @(negedge clk);
                            check("post_rst_done",  32'(bus.done), 0);
                            check("post_rst_valid", 32'(bus.code_valid), 0);
                        end
                        finished = 1'b1;
                    end
                end else begin
                    held = 1'b1;
                    hs = bus.code_sym;
                    hl = bus.code_len;
                    hc = bus.code;
                end
            end else begin
                held = 1'b0;
            end
            if (!finished) @(negedge clk);
        end
        if (!finished) check("timeout", 0, 1);
    endtask

    task automatic load_req030();
        clear_tbl();
        tb_bits[1] = 1; tb_bits[2] = 1; tb_bits[3] = 2;
        tb_hv[0] = 8'h41; tb_hv[1] = 8'h42; tb_hv[2] = 8'h43; tb_hv[3] = 8'h44;
    endtask

    task automatic load_req031();
        clear_tbl();
        tb_bits[1] = 1; tb_bits[2] = 1; tb_bits[3] = 1; tb_bits[5] = 2;
    endtask

    initial begin
        int tot, bin;
        bus.start          = 1'b0;
        bus.code_ready     = 1'b0;
        bus.bits_packed    = '0;
        bus.huffval_packed = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        load_req030();
        run_table(0, -1, 1'b0);

        load_req031();
        run_table(0, -1, 1'b0);

        clear_tbl();
        run_table(0, -1, 1'b1);

        clear_tbl();
        tb_bits[4] = 17;
        run_table(0, -1, 1'b0);
        repeat (5) @(negedge clk);
        check("err_held_idle", 32'(bus.err), 1);

        load_req030();
        run_table(2, -1, 1'b0);

        load_req031();
        run_table(0, 1, 1'b0);
        load_req030();
        run_table(0, -1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            clear_tbl();
            tot = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(1, 10));
            for (int k = 0; k < tot; k++) begin
                bin = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, MAX_BITS)) : int'($urandom_range(1, 6));
                tb_bits[bin]++;
            end
            run_table(1, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/huff_code_sched.md
HUFF_CODE_SCHED -- requirements
Module: huff_code_sched

Interface
REQ-001 SHALL have parameter SYMBOLS, default 16: maximum symbols per table.
REQ-002 SHALL have parameter MAX_BITS, default 16: number of input length bins; bin 1 is the shortest length.
REQ-003 SHALL have parameter MAX_LEN, default 4: code-length limit, 1..MAX_BITS.
REQ-004 SHALL have port clk, input, 1: clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request to process a table; accepted only in IDLE.
REQ-007 SHALL have port bits_packed, input, 8*MAX_BITS: BITS[L] at [8L-1 -: 8] is the count of codes of length L.
REQ-008 SHALL have port huffval_packed, input, 8*SYMBOLS: symbol n at [8n+7 -: 8], in canonical order.
REQ-009 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-010 SHALL have port code_valid, output, 1: an emitted code is present.
REQ-011 SHALL have port code_ready, input, 1: consumer accepts the code.
REQ-012 SHALL have ports code_sym (8), code_len (5) and code (16), outputs: the emitted symbol, its length and its right-aligned code.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at the end of processing.
REQ-014 SHALL have port err, output, 1: the table is invalid; held until the next accepted start.

Function
REQ-015 The FSM SHALL use the states IDLE, LOAD, CHECK, ADJ_SEARCH, ADJ_APPLY, EMIT and FIN.
REQ-016 In IDLE, when start=1, the block SHALL latch bits_packed and huffval_packed, clear err and go to LOAD; start is ignored in every other state.
REQ-017 LOAD SHALL sum the BITS entries into a 12-bit total over MAX_BITS cycles, one bin per cycle.
REQ-018 CHECK SHALL set err and go to FIN if total > SYMBOLS or total > 2^MAX_LEN; if total = 0 it SHALL go to FIN with err=0; otherwise it SHALL set i=MAX_BITS and go to ADJ_SEARCH.
REQ-019 ADJ_SEARCH SHALL go to EMIT when i <= MAX_LEN.
REQ-019a In ADJ_SEARCH, if BITS[i]=0 it SHALL decrement i.
REQ-019b In ADJ_SEARCH, if BITS[i]>0 it SHALL set j=i-2 and decrement j by one per cycle until BITS[j]>0, then go to ADJ_APPLY.
REQ-019c In ADJ_SEARCH, if j reaches 0 without finding BITS[j]>0, it SHALL set err and go to FIN.
REQ-020 ADJ_APPLY SHALL, in one cycle, do BITS[i]-=2, BITS[i-1]+=1, BITS[j+1]+=2 and BITS[j]-=1, then return to ADJ_SEARCH with i unchanged.
REQ-020a If BITS[i]=1 at ADJ_APPLY, the block SHALL set err and go to FIN.
REQ-021 EMIT SHALL start with L=1, code=0 and symbol index n=0.
REQ-021a In EMIT, when the remaining count of length L is 0, the block SHALL do code<<=1 and L+=1 in one cycle with code_valid=0.
REQ-021b In EMIT, when the remaining count of length L is nonzero, the block SHALL present code_valid=1, code_sym=HUFFVAL[n], code_len=L and the current code.
REQ-022 A code SHALL transfer when code_valid and code_ready are both 1; on transfer the block SHALL do code+=1, n+=1 and decrement the remaining count.
REQ-022a While code_valid=1 and code_ready=0, code_sym, code_len and code SHALL hold stable.
REQ-023 After the last transfer (n=total), the block SHALL go to FIN; at most one code transfers per cycle.
REQ-024 FIN SHALL pulse done for exactly one cycle, with err valid in that cycle, and then return to IDLE.
REQ-025 busy SHALL deassert in the same cycle done is asserted.
REQ-025a A start asserted in that FIN cycle SHALL be ignored; a start in the following cycle SHALL be accepted.
REQ-026 All BITS arithmetic SHALL be 8-bit unsigned; code arithmetic SHALL be 16-bit; MAX_LEN <= 16 guarantees no code overflow.

Reset
REQ-027 When rst=1, the block SHALL asynchronously enter IDLE and clear busy, code_valid, done, err, code_sym, code_len, code and all latched tables to 0.
REQ-028 Reset SHALL take effect in any state, including mid-EMIT with a pending code, with no further transfers or done pulse.

Configuration
REQ-029 Macro HUFF_SCHED_ADJ_COUNT_EN: when defined, the block SHALL add output adj_count (16 bits), cleared on accepted start and on rst, incremented once per ADJ_APPLY cycle and saturating at 16'hFFFF.
REQ-029a When HUFF_SCHED_ADJ_COUNT_EN is undefined, adj_count and its logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-030 BITS[1..3]={1,1,2}, huffval={A,B,C,D}, code_ready=1 -> emits A/1/0, B/2/10, C/3/110, D/3/111, then one done pulse with err=0.
REQ-031 BITS[1]=1, BITS[2]=1, BITS[3]=1, BITS[5]=2, MAX_LEN=4 -> exactly one ADJ_APPLY (adj_count=1), giving BITS={1,1,0,3}; emits codes 0, 10, 1100, 1101, 1110.
REQ-032 All BITS=0 -> no code_valid, done pulses, err=0.
REQ-033 BITS[4]=17, MAX_LEN=4 -> no code_valid, done pulses, err=1 held until the next start.
REQ-034 code_ready held low for 3 cycles on the second code -> code_valid, code_sym, code_len and code are unchanged across those cycles; the full sequence completes correctly.
REQ-035 rst pulsed during EMIT after 1 transfer -> all outputs 0 immediately; a new start then processes a full table correctly.
